// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: feeds one operand bit pair per cycle, LSB first, through a single
// full-adder cell and assembles a WIDTH-bit sum plus carry-out behind a start/busy/done handshake.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic             cf_q;
  logic [CW-1:0]    cnt_q;
  logic             fa_sum;
  logic             fa_carry;

  assign fa_sum   = sa_q[0] ^ sb_q[0] ^ cf_q;
  assign fa_carry = (sa_q[0] & sb_q[0]) | (cf_q & (sa_q[0] ^ sb_q[0]));

  // New sum bit enters at the MSB; written as shift-then-insert so WIDTH=1 stays legal.
  always_comb begin
    acc_d            = acc_q >> 1;
    acc_d[WIDTH-1]   = fa_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      acc_q   <= '0;
      cf_q    <= 1'b0;
      cnt_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          // Accepting from DONE gives back-to-back operation without an idle gap.
          if (start) begin
            sa_q    <= a;
            sb_q    <= b;
            cf_q    <= cin;
            cnt_q   <= '0;
            acc_q   <= '0;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          acc_q <= acc_d;
          cf_q  <= fa_carry;
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LastBit) begin
            sum     <= acc_d;
            cout    <= fa_carry;
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);

endmodule
